// File: rtl/cook_sequencer_pkg.sv
// Shared types and constants for the microwave cook sequencer.
// Holds the FSM state encoding, default timing constants and a one-hot helper.
package cook_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ENTRY  = 3'd1,
        LOAD   = 3'd2,
        COOK   = 3'd3,
        PAUSED = 3'd4,
        DONE   = 3'd5
    } state_e;

    localparam int DIV_DEF        = 100;
    localparam int KEY_STABLE_DEF = 3;
    localparam int LOAD_LEN       = 3;
    localparam int BCD_W          = 4;

    function automatic logic is_onehot10(input logic [9:0] v);
        return (v != 10'd0) && ((v & (v - 10'd1)) == 10'd0);
    endfunction

endpackage

// File: rtl/cook_sequencer_if.sv
// Panel/timer bundle of the cook sequencer.
// master: sequencer side (buttons/keys in, timer/magnetron/display out); slave: environment.
interface cook_sequencer_if;

    logic [0:9] keypad;
    logic       startn;
    logic       stopn;
    logic       door_closed;
    logic       timer_zero;
    logic [3:0] bcd;
    logic       loadn;
    logic       timer_clk;
    logic       mag_on;
    logic [3:0] entry_min;
    logic [3:0] entry_tens;
    logic [3:0] entry_ones;
    logic       beep;

    modport master (
        input  keypad, startn, stopn, door_closed, timer_zero,
        output bcd, loadn, timer_clk, mag_on,
        output entry_min, entry_tens, entry_ones, beep
    );

    modport slave (
        output keypad, startn, stopn, door_closed, timer_zero,
        input  bcd, loadn, timer_clk, mag_on,
        input  entry_min, entry_tens, entry_ones, beep
    );

endinterface

// File: rtl/cook_sequencer_key_scanner.sv
// Keypad debounce: one accept pulse per press once a single key is stable.
// Ports: clk_i, rst_ni, keypad_i[0:9] (bit i = digit i), accept_o (1 cycle), digit_o.
module cook_sequencer_key_scanner
    import cook_sequencer_pkg::*;
#(
    parameter int KEY_STABLE = KEY_STABLE_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [0:9]       keypad_i,
    output logic             accept_o,
    output logic [BCD_W-1:0] digit_o
);

    localparam int CW = $clog2(KEY_STABLE + 1);

    logic [0:9]       last_q;
    logic [CW-1:0]    run_q, run_d;
    logic             held_q, held_d;
    logic             acc_q, fire_d;
    logic [BCD_W-1:0] dig_q, enc_d;

    // run_d: length of the run of identical samples including this one
    always_comb begin
        run_d = CW'(1);
        if (keypad_i == last_q) begin
            run_d = (run_q == CW'(KEY_STABLE)) ? run_q : run_q + 1'b1;
        end
    end

    always_comb begin
        enc_d = '0;
        for (int i = 0; i < 10; i++) begin
            if (keypad_i[i]) enc_d = BCD_W'(i);
        end
    end

    assign fire_d = is_onehot10(keypad_i) && (run_d == CW'(KEY_STABLE))
                    && !held_q;

    // Re-arm only once the pad reads all-zero
    always_comb begin
        held_d = held_q;
        if (keypad_i == '0) held_d = 1'b0;
        else if (fire_d)    held_d = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= '0;
            run_q  <= '0;
            held_q <= 1'b0;
            acc_q  <= 1'b0;
            dig_q  <= '0;
        end else begin
            last_q <= keypad_i;
            run_q  <= run_d;
            held_q <= held_d;
            acc_q  <= fire_d;
            dig_q  <= enc_d;
        end
    end

    assign accept_o = acc_q;
    assign digit_o  = dig_q;

endmodule

// File: rtl/cook_sequencer.sv
// Microwave cook controller: M:SS keypad entry, serial timer load, cook/pause/done FSM.
// Ports: clk_100Hz, clearn (async, active low), bus (cook_sequencer_if.master).
// Build option MW_DONE_BEEP_EN: enables the done alarm on beep; otherwise beep is 0.
module cook_sequencer
    import cook_sequencer_pkg::*;
#(
    parameter int DIV        = DIV_DEF,
    parameter int KEY_STABLE = KEY_STABLE_DEF
) (
    input logic              clk_100Hz,
    input logic              clearn,
    cook_sequencer_if.master bus
);

    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

    state_e           state_q;
    logic [BCD_W-1:0] min_q, tens_q, ones_q;
    logic [BCD_W-1:0] bcd_q;
    logic             loadn_q;
    logic             tclk_q;
    logic [DW-1:0]    div_q;
    logic [1:0]       ld_q;
    logic             start_q, stop_q;

    logic             key_acc;
    logic [BCD_W-1:0] key_dig;
    logic             start_ev, stop_ev, entry_nz;

    cook_sequencer_key_scanner #(
        .KEY_STABLE (KEY_STABLE)
    ) u_keys (
        .clk_i    (clk_100Hz),
        .rst_ni   (clearn),
        .keypad_i (bus.keypad),
        .accept_o (key_acc),
        .digit_o  (key_dig)
    );

    // Falling edge of the active-low buttons against their last sample
    assign start_ev = start_q & ~bus.startn;
    assign stop_ev  = stop_q & ~bus.stopn;
    assign entry_nz = ({min_q, tens_q, ones_q} != '0);

    always_ff @(posedge clk_100Hz or negedge clearn) begin
        if (!clearn) begin
            state_q <= IDLE;
            min_q   <= '0;
            tens_q  <= '0;
            ones_q  <= '0;
            bcd_q   <= '0;
            loadn_q <= 1'b1;
            tclk_q  <= 1'b0;
            div_q   <= '0;
            ld_q    <= '0;
            start_q <= 1'b1;
            stop_q  <= 1'b1;
        end else begin
            start_q <= bus.startn;
            stop_q  <= bus.stopn;
            tclk_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (key_acc) begin
                        min_q   <= tens_q;
                        tens_q  <= ones_q;
                        ones_q  <= key_dig;
                        state_q <= ENTRY;
                    end
                end
                ENTRY: begin
                    if (stop_ev) begin
                        min_q   <= '0;
                        tens_q  <= '0;
                        ones_q  <= '0;
                        state_q <= IDLE;
                    end else if (start_ev && bus.door_closed && entry_nz) begin
                        loadn_q <= 1'b0;
                        bcd_q   <= min_q;
                        tclk_q  <= 1'b1;
                        ld_q    <= '0;
                        state_q <= LOAD;
                    end else if (key_acc) begin
                        min_q  <= tens_q;
                        tens_q <= ones_q;
                        ones_q <= key_dig;
                    end
                end
                LOAD: begin
                    if (ld_q == 2'(LOAD_LEN - 1)) begin
                        loadn_q <= 1'b1;
                        bcd_q   <= '0;
                        div_q   <= '0;
                        state_q <= COOK;
                    end else begin
                        bcd_q  <= (ld_q == 2'd0) ? tens_q : ones_q;
                        tclk_q <= 1'b1;
                        ld_q   <= ld_q + 2'd1;
                    end
                end
                COOK: begin
                    if (bus.timer_zero) begin
                        state_q <= DONE;
                    end else if (!bus.door_closed || stop_ev) begin
                        state_q <= PAUSED;
                    end else if (div_q == DW'(DIV - 1)) begin
                        div_q  <= '0;
                        tclk_q <= 1'b1;
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                PAUSED: begin
                    if (stop_ev) begin
                        min_q   <= '0;
                        tens_q  <= '0;
                        ones_q  <= '0;
                        state_q <= IDLE;
                    end else if (start_ev && bus.door_closed) begin
                        state_q <= COOK;
                    end
                end
                DONE: begin
                    if (stop_ev || start_ev) begin
                        min_q   <= '0;
                        tens_q  <= '0;
                        ones_q  <= '0;
                        state_q <= IDLE;
                    end else if (key_acc) begin
                        min_q   <= '0;
                        tens_q  <= '0;
                        ones_q  <= key_dig;
                        state_q <= ENTRY;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef MW_DONE_BEEP_EN
    localparam int HALF = DIV / 2;

    logic [DW-1:0] bcnt_q;
    logic [2:0]    btog_q;
    logic          beep_q;
    logic          done_exit;

    assign done_exit = stop_ev | start_ev | key_acc;

    // Six half-periods in DONE, ending low; cleared on the leaving edge
    always_ff @(posedge clk_100Hz or negedge clearn) begin
        if (!clearn) begin
            bcnt_q <= '0;
            btog_q <= '0;
            beep_q <= 1'b0;
        end else if (state_q != DONE || done_exit) begin
            bcnt_q <= '0;
            btog_q <= '0;
            beep_q <= 1'b0;
        end else if (btog_q != 3'd6) begin
            if (bcnt_q == DW'(HALF - 1)) begin
                bcnt_q <= '0;
                btog_q <= btog_q + 3'd1;
                beep_q <= ~beep_q;
            end else begin
                bcnt_q <= bcnt_q + 1'b1;
            end
        end
    end

    assign bus.beep = beep_q;
`else
    assign bus.beep = 1'b0;
`endif

    assign bus.bcd        = bcd_q;
    assign bus.loadn      = loadn_q;
    assign bus.timer_clk  = tclk_q;
    // Drops in the same cycle the door opens, ahead of the state change
    assign bus.mag_on     = (state_q == COOK) & bus.door_closed;
    assign bus.entry_min  = min_q;
    assign bus.entry_tens = tens_q;
    assign bus.entry_ones = ones_q;

endmodule
